or1200_ic_tag_ctrl: RTL
=======================

OR1200_IC_TAG_CTRL -- requirements
Module: or1200_ic_tag_ctrl

Interface
REQ-001 Parameter AW, default 8, tag RAM index width (2**AW entries).
REQ-002 Parameter DW, default 20, tag RAM word width; bit DW-1 = valid, bits DW-2:0 = tag.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 lkp_req/lkp_idx/lkp_tag  in  1/AW/DW-1  fetch lookup request, index, compare tag.
REQ-006 lkp_gnt  out  1  lookup accepted this cycle.
REQ-007 lkp_vld/lkp_hit  out  1/1  lookup result strobe and hit flag.
REQ-008 fill_req/fill_idx/fill_tag  in  1/AW/DW-1  refill write of {1,fill_tag}; fill_gnt out 1 accept.
REQ-009 inv_req/inv_idx  in  1/AW  single-entry invalidate (SPR ICBIR); inv_gnt out 1 accept.
REQ-010 flush_req  in  1  invalidate-all request, level; busy out 1 high while flushing.
REQ-011 ram_ce/ram_we/ram_addr/ram_di  out  1/1/AW/DW  tag RAM port; ram_doq in DW, read data one cycle after ram_ce with ram_we=0.

Function
REQ-012 FSM states IDLE, FLUSH; INIT only when REQ-026 macro defined.
REQ-013 IDLE: at most one RAM access per cycle; fixed priority inv > fill > lkp; requests are level-held until granted.
REQ-014 Grant is combinational and lasts exactly one cycle per access; ungranted requesters see gnt=0 and hold.
REQ-015 inv grant: ram_ce=1, ram_we=1, ram_addr=inv_idx, ram_di=0.
REQ-016 fill grant: ram_ce=1, ram_we=1, ram_addr=fill_idx, ram_di={1'b1,fill_tag}.
REQ-017 lkp grant in cycle N: ram_ce=1, ram_we=0, ram_addr=lkp_idx; lkp_tag registered.
REQ-018 Cycle N+1: lkp_vld=1, lkp_hit=ram_doq[DW-1] & (ram_doq[DW-2:0]==registered tag); ram_ce forced 1 this cycle (read data gated by ce).
REQ-019 Back-to-back lookups allowed: a grant may issue in N+1 while N's result is presented.
REQ-020 A write granted in N+1 to the same index does not alter N's result.
REQ-021 flush_req in IDLE (priority over all) -> FLUSH next cycle; counter=0; busy=1 from that cycle.
REQ-022 FLUSH: each cycle write 0 to ram_addr=counter, counter+1; after entry 2**AW-1 -> IDLE; exactly 2**AW cycles.
REQ-023 FLUSH: all gnt=0; flush_req ignored (no restart); pending lkp_vld from prior cycle still delivered.
REQ-024 lkp_hit=0 whenever lkp_vld=0.

Reset
REQ-025 rst low: state->INIT (macro) or IDLE, counter=0, lkp_vld=0, registered tag=0; all outputs 0, busy=1 in INIT; reset mid-flush aborts and restarts per this rule.

Configuration
REQ-026 OR1200_IC_TAG_CTRL_INIT_FLUSH_EN defined: after reset enters INIT, behaves as FLUSH (2**AW zero writes, busy=1, no grants), then IDLE.
REQ-027 Undefined: reset goes straight to IDLE, busy=0; RAM relies on its own reset clear.

Structure
REQ-028 Shared package or1200_ic_pkg holds FSM state enum and valid-bit position constant.
REQ-029 One sub-module or1200_ic_tag_arb: combinational priority grant (inv/fill/lkp); counter and FSM stay in top.

Verification
REQ-030 Fill idx 5 tag 0x1234, then lookup idx 5 tag 0x1234 -> lkp_vld next cycle, lkp_hit=1; tag 0x1235 -> hit=0.
REQ-031 inv, fill, lkp all asserted same cycle -> inv_gnt, then fill_gnt, then lkp_gnt in three consecutive cycles.
REQ-032 flush_req one cycle with AW=3 -> busy 8 cycles, ram_addr 0..7 with we=1 di=0, then lookup of any filled idx -> hit=0.
REQ-033 lkp_req held during flush -> lkp_gnt=0 all 8 cycles, granted first cycle after busy falls.
REQ-034 rst asserted at flush counter=3 -> outputs 0 immediately; with macro, full INIT walk from 0 follows.
REQ-035 Lookup idx 2 in N, fill idx 2 new tag in N+1 -> N result uses old tag; lookup in N+2 hits new tag.

Source files
------------

// File: rtl/or1200_ic_pkg.sv
// Shared definitions for the OR1200 instruction-cache tag controller:
// FSM state encoding and the position of the valid bit in a tag word.
package or1200_ic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_INIT  = 2'd2
  } ic_state_t;

  // Valid bit position for the default 20-bit tag word.
  localparam int IC_DW_DEF   = 20;
  localparam int IC_VLD_BIT  = IC_DW_DEF - 1;

  // Valid bit sits in the MSB of a tag word of any width.
  function automatic int ic_vld_bit(input int dw);
    return dw - 1;
  endfunction

endpackage

// File: rtl/or1200_ic_tag_arb.sv
// Fixed-priority single-port arbiter for the tag RAM: inv > fill > lkp.
// Purely combinational; en removes every grant (busy, flush pending, reset).
module or1200_ic_tag_arb (
  input  logic en,
  input  logic inv_req,
  input  logic fill_req,
  input  logic lkp_req,
  output logic inv_gnt,
  output logic fill_gnt,
  output logic lkp_gnt
);

  // one grant at most, highest-priority requester wins
  always_comb begin
    inv_gnt  = 1'b0;
    fill_gnt = 1'b0;
    lkp_gnt  = 1'b0;
    if (en) begin
      if (inv_req)       inv_gnt  = 1'b1;
      else if (fill_req) fill_gnt = 1'b1;
      else if (lkp_req)  lkp_gnt  = 1'b1;
    end
  end

endmodule

// File: rtl/or1200_ic_tag_ctrl.sv
// OR1200 instruction-cache tag controller: arbitrates lookup, refill and
// single-entry invalidate onto one tag RAM port and walks the RAM to clear
// it on flush. Optional macro OR1200_IC_TAG_CTRL_INIT_FLUSH_EN adds a full
// clearing walk (INIT) straight out of reset.
//
//   state | meaning
//   IDLE  | serve inv/fill/lkp one access per cycle
//   FLUSH | write zero to entry cnt each cycle, 2**AW cycles
//   INIT  | same walk as FLUSH, entered from reset (macro builds only)
module or1200_ic_tag_ctrl
  import or1200_ic_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          lkp_req,
  input  logic [AW-1:0] lkp_idx,
  input  logic [DW-2:0] lkp_tag,
  output logic          lkp_gnt,
  output logic          lkp_vld,
  output logic          lkp_hit,
  input  logic          fill_req,
  input  logic [AW-1:0] fill_idx,
  input  logic [DW-2:0] fill_tag,
  output logic          fill_gnt,
  input  logic          inv_req,
  input  logic [AW-1:0] inv_idx,
  output logic          inv_gnt,
  input  logic          flush_req,
  output logic          busy,
  output logic          ram_ce,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_di,
  input  logic [DW-1:0] ram_doq
);

  localparam int VB = ic_vld_bit(DW);

`ifdef OR1200_IC_TAG_CTRL_INIT_FLUSH_EN
  localparam ic_state_t RST_STATE = ST_INIT;
`else
  localparam ic_state_t RST_STATE = ST_IDLE;
`endif

  ic_state_t     state;
  logic [AW-1:0] cnt;
  logic [DW-2:0] tag_q;
  logic          arb_en;

  // reset gates grants so all outputs drop the moment rst goes low
  assign arb_en = rst & (state == ST_IDLE) & ~flush_req;
  assign busy   = (state != ST_IDLE);

  or1200_ic_tag_arb u_arb (
    .en       (arb_en),
    .inv_req  (inv_req),
    .fill_req (fill_req),
    .lkp_req  (lkp_req),
    .inv_gnt  (inv_gnt),
    .fill_gnt (fill_gnt),
    .lkp_gnt  (lkp_gnt)
  );

  // result is valid only on the strobe; compare against the tag captured at grant
  assign lkp_hit = lkp_vld & ram_doq[VB] & (ram_doq[VB-1:0] == tag_q);

  // FSM, clear-walk counter and lookup result pipeline
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= RST_STATE;
      cnt     <= '0;
      lkp_vld <= 1'b0;
      tag_q   <= '0;
    end else begin
      lkp_vld <= lkp_gnt;
      if (lkp_gnt) tag_q <= lkp_tag;
      unique case (state)
        ST_IDLE: begin
          if (flush_req) begin
            state <= ST_FLUSH;
            cnt   <= '0;
          end
        end
        ST_FLUSH, ST_INIT: begin
          cnt <= cnt + AW'(1);
          if (&cnt) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // tag RAM port mux; ce stays high in the result cycle so read data is held
  always_comb begin
    ram_ce   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_di   = '0;
    if (rst) begin
      if (busy) begin
        ram_ce   = 1'b1;
        ram_we   = 1'b1;
        ram_addr = cnt;
      end else if (inv_gnt) begin
        ram_ce   = 1'b1;
        ram_we   = 1'b1;
        ram_addr = inv_idx;
      end else if (fill_gnt) begin
        ram_ce   = 1'b1;
        ram_we   = 1'b1;
        ram_addr = fill_idx;
        ram_di   = {1'b1, fill_tag};
      end else if (lkp_gnt) begin
        ram_ce   = 1'b1;
        ram_addr = lkp_idx;
      end
      if (lkp_vld) ram_ce = 1'b1;
    end
  end

endmodule
